// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data port arbiter onto one single-port memory, falling-edge clocked
// Optional build macro ARB_ROUND_ROBIN_EN: alternate winners on conflicts (default: data always wins)
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic              CLK,
   input  logic              Reset_L,
   input  logic              ifReq,
   input  logic [ADDR_W-1:0] ifAddr,
   output logic [DATA_W-1:0] ifRdata,
   output logic              ifDone,
   input  logic              dReq,
   input  logic              dWe,
   input  logic [ADDR_W-1:0] dAddr,
   input  logic [DATA_W-1:0] dWdata,
   output logic [DATA_W-1:0] dRdata,
   output logic              dDone,
   output logic              stallIF,
   output logic              stallMEM,
   output logic              mReq,
   output logic              mWe,
   output logic [ADDR_W-1:0] mAddr,
   output logic [DATA_W-1:0] mWdata,
   input  logic [DATA_W-1:0] mRdata,
   input  logic              mReady,
   output logic              busErr
);

   typedef enum logic [1:0] {IDLE = 2'd0, IF_BUSY = 2'd1, D_BUSY = 2'd2} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [7:0]        r_wait;
   logic              r_ifDone;
   logic              r_dDone;
   logic              r_busErr;
   logic              r_mWe;
   logic [ADDR_W-1:0] r_mAddr;
   logic [DATA_W-1:0] r_mWdata;
   logic [DATA_W-1:0] r_ifRdata;
   logic [DATA_W-1:0] r_dRdata;

   logic w_busy;
   logic w_timeout;
   logic w_finish;
   logic w_grant;
   logic w_grant_d;
   logic w_prio_d;

   assign w_busy    = (r_state != IDLE);
   assign w_timeout = w_busy & ~mReady & (r_wait == 8'(MAX_WAIT - 1));
   assign w_finish  = w_busy & (mReady | w_timeout);

`ifdef ARB_ROUND_ROBIN_EN
   logic r_prio_d;

   always_ff @(negedge CLK or negedge Reset_L) begin
      if (!Reset_L)
         r_prio_d <= 1'b1;
      else if ((r_state == IDLE) && ifReq && dReq)
         r_prio_d <= ~r_prio_d;
   end

   assign w_prio_d = r_prio_d;
`else
   assign w_prio_d = 1'b1;
`endif

   // A completing requester still holds Req this edge, so only the other port may chain.
   always_comb begin
      w_grant   = 1'b0;
      w_grant_d = 1'b0;
      case (r_state)
         IDLE: begin
            w_grant   = ifReq | dReq;
            w_grant_d = dReq & (~ifReq | w_prio_d);
         end
         IF_BUSY: begin
            w_grant   = w_finish & dReq;
            w_grant_d = 1'b1;
         end
         D_BUSY: begin
            w_grant   = w_finish & ifReq;
            w_grant_d = 1'b0;
         end
         default: begin
            w_grant   = 1'b0;
            w_grant_d = 1'b0;
         end
      endcase
   end

   always_ff @(negedge CLK or negedge Reset_L) begin
      if (!Reset_L)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_grant)
         w_next = w_grant_d ? D_BUSY : IF_BUSY;
      else if (w_finish)
         w_next = IDLE;
   end

   always_comb begin
      mReq = w_busy;
   end

   always_ff @(negedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         r_wait    <= '0;
         r_ifDone  <= 1'b0;
         r_dDone   <= 1'b0;
         r_busErr  <= 1'b0;
         r_mWe     <= 1'b0;
         r_mAddr   <= '0;
         r_mWdata  <= '0;
         r_ifRdata <= '0;
         r_dRdata  <= '0;
      end else begin
         r_ifDone <= 1'b0;
         r_dDone  <= 1'b0;
         if (w_finish) begin
            if (r_state == IF_BUSY) begin
               r_ifDone  <= 1'b1;
               r_ifRdata <= mReady ? mRdata : '0;
            end else begin
               r_dDone  <= 1'b1;
               r_dRdata <= (mReady && !r_mWe) ? mRdata : '0;
            end
            if (w_timeout)
               r_busErr <= 1'b1;
         end
         if (w_grant) begin
            r_wait <= '0;
            if (w_grant_d) begin
               r_mAddr  <= dAddr;
               r_mWdata <= dWdata;
               r_mWe    <= dWe;
            end else begin
               r_mAddr  <= ifAddr;
               r_mWdata <= '0;
               r_mWe    <= 1'b0;
            end
         end else if (w_finish) begin
            r_mWe <= 1'b0;
         end else if (w_busy) begin
            r_wait <= r_wait + 8'd1;
         end
      end
   end

   assign ifDone   = r_ifDone;
   assign dDone    = r_dDone;
   assign ifRdata  = r_ifRdata;
   assign dRdata   = r_dRdata;
   assign busErr   = r_busErr;
   assign mWe      = r_mWe;
   assign mAddr    = r_mAddr;
   assign mWdata   = r_mWdata;
   assign stallIF  = ifReq & ~r_ifDone;
   assign stallMEM = dReq & ~r_dDone;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        CLK = 1'b1;
   logic        Reset_L;
   logic        ifReq, dReq, dWe, mReady;
   logic [31:0] ifAddr, dAddr, dWdata, mRdata;
   logic [31:0] ifRdata, dRdata, mAddr, mWdata;
   logic        ifDone, dDone, stallIF, stallMEM, mReq, mWe, busErr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
      .CLK(CLK), .Reset_L(Reset_L),
      .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifDone(ifDone),
      .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
      .dRdata(dRdata), .dDone(dDone),
      .stallIF(stallIF), .stallMEM(stallMEM),
      .mReq(mReq), .mWe(mWe), .mAddr(mAddr), .mWdata(mWdata),
      .mRdata(mRdata), .mReady(mReady), .busErr(busErr)
   );

   typedef struct {
      logic        if_req, d_req, d_we, m_ready;
      logic [31:0] d_addr;
      logic        e_mreq, e_mwe, e_ifdone, e_ddone, e_stif, e_stmem;
      logic [31:0] e_maddr, e_mwdata, e_rdata;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic ir, input logic dr, input logic we, input logic rdy,
                              input logic [31:0] da, input logic emr, input logic emw,
                              input logic eid, input logic edd, input logic esi, input logic esm,
                              input logic [31:0] ema, input logic [31:0] emwd, input logic [31:0] erd);
      vec_t t;
      t.if_req = ir; t.d_req = dr; t.d_we = we; t.m_ready = rdy; t.d_addr = da;
      t.e_mreq = emr; t.e_mwe = emw; t.e_ifdone = eid; t.e_ddone = edd;
      t.e_stif = esi; t.e_stmem = esm; t.e_maddr = ema; t.e_mwdata = emwd; t.e_rdata = erd;
      return t;
   endfunction

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // one falling (active) edge passes; sampling happens just after the rising edge
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic run_grants(input int n, input bit hold, output logic [3:0] seq);
      int k;
      seq = 4'b0; k = 0;
      ifReq = 1'b1; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h40;
      ifAddr = 32'h0040_0000; mReady = 1'b1;
      for (int c = 0; c < 12 && k < n; c++) begin
         cyc();
         if (mReq) begin
            seq[k] = (mAddr == 32'h40);
            k++;
         end
         if (!hold) begin
            if (ifDone) ifReq = 1'b0;
            if (dDone)  dReq  = 1'b0;
         end
      end
      ifReq = 1'b0; dReq = 1'b0;
      repeat (3) cyc();
      chk32("grant_count", 32'(k), 32'(n));
   endtask

   initial begin
      logic [3:0]  seq;
      int          busy, seen;
      bit          if_pend, d_pend, d_we_q;
      logic [31:0] if_addr_q, d_addr_q, d_wd_q;
      int          if_gap, d_gap, if_wait, d_wait, beat, served, owner;

      Reset_L = 1'b0; ifReq = 1'b0; dReq = 1'b0; dWe = 1'b0; mReady = 1'b0;
      ifAddr = 32'h0040_0000; dAddr = '0; dWdata = 32'hCAFE_F00D; mRdata = 32'h8C22_0004;
      cyc(); cyc();
      chk1("rst_mReq", mReq, 1'b0);
      chk1("rst_mWe", mWe, 1'b0);
      chk1("rst_ifDone", ifDone, 1'b0);
      chk1("rst_dDone", dDone, 1'b0);
      chk1("rst_busErr", busErr, 1'b0);
      chk32("rst_mAddr", mAddr, 32'h0);
      chk32("rst_mWdata", mWdata, 32'h0);
      chk32("rst_ifRdata", ifRdata, 32'h0);
      chk32("rst_dRdata", dRdata, 32'h0);
      Reset_L = 1'b1;

      //                ir  dr  we  rdy  dAddr   mReq mWe ifD dD  stI stM mAddr          mWdata         rdata
      tbl.push_back(v(0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0));
      tbl.push_back(v(0, 0, 0, 1, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,          32'h0,         32'h0));
      tbl.push_back(v(1, 0, 0, 1, 32'h0,  1, 0, 0, 0, 1, 0, 32'h0040_0000,  32'h0,         32'h0));
      tbl.push_back(v(1, 0, 0, 1, 32'h0,  0, 0, 1, 0, 0, 0, 32'h0040_0000,  32'h0,         32'h8C22_0004));
      tbl.push_back(v(0, 0, 0, 1, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0040_0000,  32'h0,         32'h0));
      tbl.push_back(v(1, 1, 0, 1, 32'h10, 1, 0, 0, 0, 1, 1, 32'h10,         32'hCAFE_F00D, 32'h0));
      tbl.push_back(v(1, 1, 0, 1, 32'h10, 1, 0, 0, 1, 1, 0, 32'h0040_0000,  32'h0,         32'h8C22_0004));
      tbl.push_back(v(1, 0, 0, 1, 32'h10, 0, 0, 1, 0, 0, 0, 32'h0040_0000,  32'h0,         32'h8C22_0004));
      tbl.push_back(v(0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0040_0000,  32'h0,         32'h0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(v(0, 1, 1, 0, 32'h20, 1, 1, 0, 0, 0, 1, 32'h20,      32'hCAFE_F00D, 32'h0));
      tbl.push_back(v(0, 1, 1, 1, 32'h20, 0, 0, 0, 1, 0, 0, 32'h20,         32'hCAFE_F00D, 32'h0));
      tbl.push_back(v(0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h20,         32'hCAFE_F00D, 32'h0));

      foreach (tbl[i]) begin
         ifReq = tbl[i].if_req; dReq = tbl[i].d_req; dWe = tbl[i].d_we;
         mReady = tbl[i].m_ready; dAddr = tbl[i].d_addr;
         cyc();
         chk1($sformatf("v%0d_mReq", i), mReq, tbl[i].e_mreq);
         chk1($sformatf("v%0d_mWe", i), mWe, tbl[i].e_mwe);
         chk1($sformatf("v%0d_ifDone", i), ifDone, tbl[i].e_ifdone);
         chk1($sformatf("v%0d_dDone", i), dDone, tbl[i].e_ddone);
         chk1($sformatf("v%0d_stallIF", i), stallIF, tbl[i].e_stif);
         chk1($sformatf("v%0d_stallMEM", i), stallMEM, tbl[i].e_stmem);
         chk32($sformatf("v%0d_mAddr", i), mAddr, tbl[i].e_maddr);
         chk32($sformatf("v%0d_mWdata", i), mWdata, tbl[i].e_mwdata);
         if (tbl[i].e_ifdone) chk32($sformatf("v%0d_ifRdata", i), ifRdata, tbl[i].e_rdata);
         if (tbl[i].e_ddone)  chk32($sformatf("v%0d_dRdata", i), dRdata, tbl[i].e_rdata);
      end
      chk1("pre_to_busErr", busErr, 1'b0);

      // timeout: memory never answers
      dReq = 1'b1; dWe = 1'b0; dAddr = 32'h30; mReady = 1'b0;
      busy = 0; seen = 0;
      for (int c = 0; c < 40 && seen == 0; c++) begin
         cyc();
         if (mReq) busy++;
         if (dDone) seen = 1;
      end
      dReq = 1'b0;
      chk32("to_done_seen", 32'(seen), 32'd1);
      chk32("to_busy_cycles", 32'(busy), 32'd15);
      chk32("to_rdata", dRdata, 32'h0);
      chk1("to_busErr", busErr, 1'b1);
      ifReq = 1'b1; mReady = 1'b1; seen = 0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
         cyc();
         if (ifDone) seen = 1;
      end
      ifReq = 1'b0;
      chk32("after_to_done_seen", 32'(seen), 32'd1);
      chk32("after_to_ifRdata", ifRdata, 32'h8C22_0004);
      chk1("after_to_busErr_sticky", busErr, 1'b1);
      cyc();

      // asynchronous reset in the middle of a data access
      dReq = 1'b1; dWe = 1'b0; dAddr = 32'h50; mReady = 1'b0;
      cyc(); cyc();
      chk1("rstmid_pre_mReq", mReq, 1'b1);
      #2 Reset_L = 1'b0;
      #1;
      chk1("rstmid_mReq", mReq, 1'b0);
      chk1("rstmid_mWe", mWe, 1'b0);
      chk1("rstmid_dDone", dDone, 1'b0);
      chk1("rstmid_busErr", busErr, 1'b0);
      chk32("rstmid_mAddr", mAddr, 32'h0);
      dReq = 1'b0;
      @(posedge CLK);
      #1 Reset_L = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cyc();
         chk1("rstmid_post_dDone", dDone, 1'b0);
         chk1("rstmid_post_mReq", mReq, 1'b0);
      end

      // two conflicts started from idle, then continuously held requests
      run_grants(2, 1'b0, seq);
      chk32("conflict1_order", 32'(seq), 32'h1);
      run_grants(2, 1'b0, seq);
`ifdef ARB_ROUND_ROBIN_EN
      chk32("conflict2_order", 32'(seq), 32'h2);
`else
      chk32("conflict2_order", 32'(seq), 32'h1);
`endif
      run_grants(4, 1'b1, seq);
      chk32("held_order", 32'(seq), 32'h5);

      // randomized traffic against a transaction-level model of the memory and both requesters
      if_pend = 0; d_pend = 0; d_we_q = 0; if_addr_q = '0; d_addr_q = '0; d_wd_q = '0;
      if_gap = 0; d_gap = 1; if_wait = 0; d_wait = 0; beat = 0; served = 0;
      mReady = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         cyc();
         chk1("rnd_ifDone", ifDone, served == 1);
         chk1("rnd_dDone", dDone, served == 2);
         if (served == 1) begin
            chk32("rnd_ifRdata", ifRdata, mem_val(if_addr_q));
            chk1("rnd_if_latency", if_wait <= 30, 1'b1);
            if_pend = 0; ifReq = 1'b0; if_gap = int'($urandom_range(0, 3));
         end
         if (served == 2) begin
            chk32("rnd_dRdata", dRdata, d_we_q ? 32'h0 : mem_val(d_addr_q));
            chk1("rnd_d_latency", d_wait <= 30, 1'b1);
            d_pend = 0; dReq = 1'b0; d_gap = int'($urandom_range(0, 3));
         end
         chk1("rnd_busErr", busErr, 1'b0);
         if (if_pend) if_wait++;
         if (d_pend)  d_wait++;

         served = 0;
         if (mReq) begin
            owner = 0;
            if (if_pend && mAddr == if_addr_q && !mWe && mWdata == 32'h0)
               owner = 1;
            else if (d_pend && mAddr == d_addr_q && mWe == d_we_q && mWdata == d_wd_q)
               owner = 2;
            chk1("rnd_bus_owner", owner != 0, 1'b1);
            beat++;
            if (owner != 0 && ($urandom_range(0, 2) == 0 || beat >= 6)) begin
               mReady = 1'b1; served = owner; beat = 0;
            end else begin
               mReady = 1'b0;
            end
         end else begin
            mReady = 1'($urandom_range(0, 1));
            beat = 0;
         end
         mRdata = mem_val(mAddr);

         if (!if_pend) begin
            if (if_gap == 0) begin
               if_pend = 1; if_wait = 0;
               if_addr_q = 32'h0040_0000 | ($urandom & 32'h0000_FFFC);
               ifAddr = if_addr_q; ifReq = 1'b1;
            end else if_gap--;
         end
         if (!d_pend) begin
            if (d_gap == 0) begin
               d_pend = 1; d_wait = 0;
               d_addr_q = 32'h1000_0000 | ($urandom & 32'h0000_FFFC);
               d_we_q = 1'($urandom_range(0, 1));
               d_wd_q = $urandom;
               dAddr = d_addr_q; dWe = d_we_q; dWdata = d_wd_q; dReq = 1'b1;
            end else d_gap--;
         end
      end
      ifReq = 1'b0; dReq = 1'b0; mReady = 1'b0;
      repeat (3) cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
